// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the layer stream sequencer.
// Holds the FSM state encoding and the counter-width helper.
// Purely declarative: no logic, no latency, no flow control.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } seq_state_t;

    // Counter width for a count of n items; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Tracks the index of the largest signed word in a streamed burst.
// Latency: idx/idx_valid register on the edge after the word flagged last.
// No backpressure: observes the stream passively, one word per valid cycle.
module argmax_tracker
    import layer_seq_pkg::*;
#(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [dataWidth-1:0]             data,
    input  logic                             valid,
    input  logic                             last,
    output logic [cnt_width(numNeurons)-1:0] idx,
    output logic                             idx_valid
);

    localparam int CW = cnt_width(numNeurons);

    logic                        first;
    logic [CW-1:0]               pos;
    logic [CW-1:0]               best_idx;
    logic signed [dataWidth-1:0] best_val;
    logic                        take;

    // A word wins only when strictly greater, so ties keep the lower index;
    // the first word of a burst always seeds the running maximum.
    always_comb begin
        take = first || ($signed(data) > best_val);
    end

    // Running maximum across the burst, published once the last word is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first     <= 1'b1;
            pos       <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
        end else begin
            idx_valid <= 1'b0;
            if (valid) begin
                if (take) begin
                    best_val <= $signed(data);
                    best_idx <= pos;
                end
                if (last) begin
                    idx       <= take ? pos : best_idx;
                    idx_valid <= 1'b1;
                    first     <= 1'b1;
                    pos       <= '0;
                end else begin
                    first <= 1'b0;
                    pos   <= pos + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/layer_stream_sequencer.sv
// Captures a layer's parallel outputs and streams them word by word, neuron 0 first.
// Latency: first word is registered one cycle after in_valid; bursts are separated by gapCycles idle cycles.
// No upstream backpressure: one early vector is held pending, further ones are dropped and flagged by sticky overrun.
// Optional argmax tracker for the final layer is built when LAYER_SEQ_ARGMAX_EN is defined.
module layer_stream_sequencer
    import layer_seq_pkg::*;
#(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16,
    parameter int gapCycles  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [numNeurons*dataWidth-1:0]  in_data,
    input  logic                             in_valid,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun,
    output logic [cnt_width(numNeurons)-1:0] argmax_idx,
    output logic                             argmax_valid
);

    localparam int            VW       = numNeurons * dataWidth;
    localparam int            CW       = cnt_width(numNeurons);
    localparam int            GW       = cnt_width(gapCycles);
    localparam logic [CW-1:0] LAST_CNT = CW'(numNeurons - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(gapCycles - 1);

    seq_state_t      state;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   gap_cnt;
    logic [VW-1:0]   shreg;
    logic [VW-1:0]   pend_dat;
    logic            pend_vld;

    // Sequencer FSM: launch, stream, gap and pending handling with registered outputs.
    // The shift register always holds the word on out_data in its low slot, so the
    // next word to present sits one slot above it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            pend_dat  <= '0;
            pend_vld  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gap_cnt <= '0;
                    if (pend_vld) begin
                        // Pending vector goes first; a fresh arrival refills the slot.
                        state     <= STREAM;
                        cnt       <= '0;
                        shreg     <= pend_dat;
                        out_data  <= pend_dat[dataWidth-1:0];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        pend_vld  <= in_valid;
                        if (in_valid) begin
                            pend_dat <= in_data;
                        end
                    end else if (in_valid) begin
                        state     <= STREAM;
                        cnt       <= '0;
                        shreg     <= in_data;
                        out_data  <= in_data[dataWidth-1:0];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                STREAM: begin
                    busy <= 1'b1;
                    if (in_valid) begin
                        if (pend_vld) begin
                            overrun <= 1'b1;
                        end else begin
                            pend_vld <= 1'b1;
                            pend_dat <= in_data;
                        end
                    end
                    if (cnt == LAST_CNT) begin
                        state     <= GAP;
                        gap_cnt   <= '0;
                        out_valid <= 1'b0;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        out_data  <= shreg[dataWidth +: dataWidth];
                        shreg     <= shreg >> dataWidth;
                        out_valid <= 1'b1;
                    end
                end

                GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        // Exit decision uses the pending flag as it stood before this edge.
                        if (pend_vld) begin
                            state     <= STREAM;
                            cnt       <= '0;
                            shreg     <= pend_dat;
                            out_data  <= pend_dat[dataWidth-1:0];
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            pend_vld  <= 1'b0;
                            if (in_valid) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            // A same-edge arrival parks in pending and launches from IDLE.
                            state <= IDLE;
                            busy  <= in_valid;
                            if (in_valid) begin
                                pend_vld <= 1'b1;
                                pend_dat <= in_data;
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                        busy    <= 1'b1;
                        if (in_valid) begin
                            if (pend_vld) begin
                                overrun <= 1'b1;
                            end else begin
                                pend_vld <= 1'b1;
                                pend_dat <= in_data;
                            end
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= pend_vld;
                end
            endcase
        end
    end

`ifdef LAYER_SEQ_ARGMAX_EN
    logic burst_last;

    // The last word of a burst is the one on the output while cnt sits at its top value.
    always_comb begin
        burst_last = out_valid && (state == STREAM) && (cnt == LAST_CNT);
    end

    argmax_tracker #(
        .numNeurons (numNeurons),
        .dataWidth  (dataWidth)
    ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .data      (out_data),
        .valid     (out_valid),
        .last      (burst_last),
        .idx       (argmax_idx),
        .idx_valid (argmax_valid)
    );
`else
    assign argmax_idx   = '0;
    assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Directed bench for layer_stream_sequencer with four neurons and a three-cycle gap.
// Inputs change one time unit after a rising edge and outputs are sampled there too.
// Covers reset, streaming order, pending, overrun, async reset mid-burst, late capture and argmax.
module tb_layer_stream_sequencer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int G  = 3;

    localparam logic [N*DW-1:0] VEC_A = {16'h8000, 16'h7FFF, 16'hFF00, 16'h0100};
    localparam logic [N*DW-1:0] VEC_B = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    localparam logic [N*DW-1:0] VEC_C = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    localparam logic [N*DW-1:0] VEC_M = {16'h0009, 16'h0009, 16'hFFFD, 16'h0005};

    logic            clk;
    logic            rst;
    logic [N*DW-1:0] in_data;
    logic            in_valid;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            busy;
    logic            overrun;
    logic [1:0]      argmax_idx;
    logic            argmax_valid;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    layer_stream_sequencer #(
        .numNeurons (N),
        .dataWidth  (DW),
        .gapCycles  (G)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .argmax_idx   (argmax_idx),
        .argmax_valid (argmax_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (argmax_valid === 1'b1) pulses <= pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks N consecutive valid words of vec, advancing one cycle per word.
    task automatic expect_burst(input string tag, input logic [N*DW-1:0] vec);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_word"}, {16'd0, out_data}, {16'd0, vec[i*DW +: DW]});
            tick();
        end
    endtask

    // Checks the G idle gap cycles that follow a burst.
    task automatic expect_gap(input string tag);
        for (int g = 0; g < G; g++) begin
            chk({tag, "_gap_valid"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_gap_busy"}, {31'd0, busy}, 32'd1);
            tick();
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_argmax_valid", {31'd0, argmax_valid}, 32'd0);
        chk("rst_argmax_idx", {30'd0, argmax_idx}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic burst: latency 1, order, gap, back to IDLE.
        in_data = VEC_A; in_valid = 1'b1;
        chk("t1_pre_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        expect_burst("t1", VEC_A);
        expect_gap("t1");
        chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        tick();

        // Pending vector arrives during STREAM; second burst right after the gap.
        in_data = VEC_A; in_valid = 1'b1;
        tick();
        in_data = VEC_B; in_valid = 1'b1;
        chk("t2_w0", {16'd0, out_data}, {16'd0, VEC_A[0 +: DW]});
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < N; i++) begin
            chk("t2_a_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_a_word", {16'd0, out_data}, {16'd0, VEC_A[i*DW +: DW]});
            tick();
        end
        expect_gap("t2");
        chk("t2_overrun", {31'd0, overrun}, 32'd0);
        expect_burst("t2_b", VEC_B);
        expect_gap("t2_b");
        chk("t2_idle_busy", {31'd0, busy}, 32'd0);
        tick();

        // Third vector while pending is full: dropped, overrun sticky.
        in_data = VEC_A; in_valid = 1'b1;
        tick();
        in_data = VEC_B;
        chk("t3_w0", {16'd0, out_data}, {16'd0, VEC_A[0 +: DW]});
        tick();
        in_data = VEC_C;
        chk("t3_pre_overrun", {31'd0, overrun}, 32'd0);
        chk("t3_w1", {16'd0, out_data}, {16'd0, VEC_A[DW +: DW]});
        tick();
        in_valid = 1'b0;
        chk("t3_overrun", {31'd0, overrun}, 32'd1);
        chk("t3_w2", {16'd0, out_data}, {16'd0, VEC_A[2*DW +: DW]});
        tick();
        chk("t3_w3", {16'd0, out_data}, {16'd0, VEC_A[3*DW +: DW]});
        tick();
        expect_gap("t3");
        expect_burst("t3_b", VEC_B);
        expect_gap("t3_b");
        chk("t3_sticky", {31'd0, overrun}, 32'd1);
        chk("t3_idle_busy", {31'd0, busy}, 32'd0);
        tick();

        // Asynchronous reset mid-burst at word 2, then a fresh burst from word 0.
        in_data = VEC_A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t4_w2", {16'd0, out_data}, {16'd0, VEC_A[2*DW +: DW]});
        #2 rst = 1'b1;
        #1;
        chk("t4_async_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_async_busy", {31'd0, busy}, 32'd0);
        chk("t4_async_overrun", {31'd0, overrun}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t4_no_resume", {31'd0, out_valid}, 32'd0);
        in_data = VEC_B; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_burst("t4_b", VEC_B);
        expect_gap("t4_b");
        tick();

        // Capture on the final gap cycle: one IDLE cycle, then the burst.
        in_data = VEC_A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_burst("t5_a", VEC_A);
        tick();
        tick();
        in_data = VEC_B; in_valid = 1'b1;
        chk("t5_lastgap_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("t5_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_idle_busy", {31'd0, busy}, 32'd1);
        tick();
        expect_burst("t5_b", VEC_B);
        expect_gap("t5_b");
        tick();

        // Argmax over {5, -3, 9, 9}: index 2, ties keep the lower index.
        in_data = VEC_M; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_burst("t6", VEC_M);
`ifdef LAYER_SEQ_ARGMAX_EN
        chk("t6_argmax_valid", {31'd0, argmax_valid}, 32'd1);
        chk("t6_argmax_idx", {30'd0, argmax_idx}, 32'd2);
        tick();
        chk("t6_argmax_pulse_end", {31'd0, argmax_valid}, 32'd0);
`else
        chk("t6_argmax_valid", {31'd0, argmax_valid}, 32'd0);
        tick();
        chk("t6_argmax_pulses", pulses, 32'd0);
`endif
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer_stream_sequencer.md
# layer_stream_sequencer

Sequences data between fully-connected layers of the network. Captures the parallel outputs of one layer's neurons when the layer asserts its output-valid, then streams them one word per cycle, neuron 0 first, as the `myinput`/`myinputValid` stream of the next layer. After each burst it enforces an idle gap so downstream neurons can finish their bias/sigmoid pass and clear their read address. A one-entry pending buffer absorbs a vector that arrives early; an optional argmax tracker serves the final layer.

## Interface
- `numNeurons`, 30: neurons in the upstream layer, which is also the burst length.
- `dataWidth`, 16: word width; matches the neuron `dataWidth`.
- `gapCycles`, 8: minimum idle cycles after each burst; must be ≥1.
- `clk` in 1: the only clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in numNeurons*dataWidth: upstream outputs; neuron i is at `[i*dataWidth +: dataWidth]`.
- `in_valid` in 1: one-cycle strobe marking `in_data` valid; the upstream layer's `outvalid`.
- `out_data` out dataWidth: streamed word; drives the next layer's `myinput`.
- `out_valid` out 1: word valid; drives the next layer's `myinputValid`.
- `busy` out 1: high in STREAM or GAP, or while the pending buffer is full.
- `overrun` out 1: sticky; set when a vector is dropped; cleared only by `rst`.
- `argmax_idx` out $clog2(numNeurons): index of the largest element of the last burst (only with the macro).
- `argmax_valid` out 1: one-cycle pulse, argmax ready (only with the macro).

## Operation
- States:
  - IDLE: `out_valid` is 0.
  - STREAM: emits `numNeurons` words back-to-back, with no bubbles.
  - GAP: counts `gapCycles` idle cycles.
- Capture:
  - `in_valid` in IDLE with pending empty: load the shift register, set `cnt`=0, go to STREAM.
  - `in_valid` in STREAM or GAP: store into the pending buffer if it is empty. If pending is full, drop the new vector (pending is kept) and set `overrun`.
  - IDLE with pending full: launch the pending vector into STREAM and clear pending.
- STREAM:
  - `out_data` = element `cnt`, and `cnt` increments each cycle.
  - When `cnt`==numNeurons-1, go to GAP with the gap counter at 0.
- GAP:
  - When the gap counter reaches gapCycles-1, go to STREAM if pending is full, otherwise to IDLE.
  - The exit decision uses the pending register value before the edge. A capture on that same edge launches from IDLE one cycle later.
- `out_data` holds its last value when `out_valid`=0; its value is don't-care.
- Words are passed through unchanged, with no arithmetic, so signed Q-format is preserved.
- Reset values, applied mid-burst as well:
  - state=IDLE, `cnt`=0, pending empty;
  - `out_valid`=0, `out_data`=0, `busy`=0, `overrun`=0;
  - `argmax_idx`=0, `argmax_valid`=0.
  - A truncated burst is not resumed.

## Timing
- `in_valid` sampled in IDLE at edge k puts the first `out_valid` at the output after edge k (registered output, latency 1).
- A burst occupies exactly `numNeurons` consecutive cycles.
- The next burst starts no earlier than `gapCycles` cycles after the last word. From pending, it starts at exactly `gapCycles`.
- `busy` and `overrun` are registered and update on the same edge as the state change.
- `argmax_valid` pulses on the edge after the last streamed word.

## Configuration
- Macro `LAYER_SEQ_ARGMAX_EN`:
  - Defined: the argmax tracker is compiled in. It compares each streamed word as signed.
    - A strictly greater word replaces the running maximum; ties keep the lower index.
    - The result is registered to `argmax_idx` with a one-cycle `argmax_valid` pulse.
  - Undefined: no tracker logic is built, and `argmax_idx` and `argmax_valid` are tied to 0.

## Structure
- Package `layer_seq_pkg`:
  - state enumeration (IDLE, STREAM, GAP);
  - function computing the counter width, `$clog2(numNeurons)` with a floor of 1.
- Sub-module `argmax_tracker`: inputs clk, rst, data, valid, last; outputs idx, idx_valid. It is instantiated under the macro.
- Top level: the FSM, burst/gap counters, shift register and pending register.

## Test plan
- numNeurons=4, gapCycles=3; `in_valid` with words {0x0100, 0xFF00, 0x7FFF, 0x8000} → `out_valid` high for 4 cycles starting 1 cycle later, words in order, then 3 idle cycles, IDLE, `busy`=0.
- Second `in_valid` during STREAM with vector {1,2,3,4} → held in pending, `busy` stays 1, second burst starts exactly 3 cycles after the first burst's last word, `overrun`=0.
- Third `in_valid` while pending is full → vector dropped, `overrun`=1 and sticky, pending burst unchanged.
- `rst` asserted asynchronously mid-burst at word 2 → `out_valid`, `busy`, `overrun` go to 0 without waiting for a clock edge; the next `in_valid` streams from word 0.
- `in_valid` on the final GAP cycle with pending empty → captured to pending; one IDLE cycle; burst starts the following cycle.
- `LAYER_SEQ_ARGMAX_EN` defined, words {5, -3, 9, 9} → `argmax_idx`=2 with a one-cycle `argmax_valid` after the last word. Undefined → `argmax_valid` never asserts.
